// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch FSM state encoding and instruction size encoding.
package cpu_pkg;

   typedef enum logic [2:0] {
      ST_ISSUE0,
      ST_CAP0,
      ST_CAP1,
      ST_CAP2,
      ST_HOLD,
      ST_ADVANCE
   } fetch_state_e;

   localparam int SIZE_FIELD_MSB = 7;
   localparam int SIZE_FIELD_LSB = 6;

   // Raw size field values found in opcode[7:6].
   localparam logic [1:0] SIZE_CODE_1B   = 2'b00;
   localparam logic [1:0] SIZE_CODE_2B   = 2'b01;
   localparam logic [1:0] SIZE_CODE_3B   = 2'b10;
   localparam logic [1:0] SIZE_CODE_RSVD = 2'b11;

   // Instruction length in bytes as seen by the PC and decoder.
   localparam logic [1:0] SIZE_1 = 2'd1;
   localparam logic [1:0] SIZE_2 = 2'd2;
   localparam logic [1:0] SIZE_3 = 2'd3;

endpackage

// File: rtl/instr_size_decode.sv
// Maps an opcode to its instruction length in bytes (1..3); shared with the decoder.
module instr_size_decode
   import cpu_pkg::*;
#(
   parameter int DATA_WIDTH = 8
) (
   input  logic [DATA_WIDTH-1:0] opcode,
   output logic [1:0]            size
);

   // Only the size field matters; the remaining opcode bits are reduced away here.
   logic unused_bits;
   assign unused_bits = ^opcode;

   always_comb begin
      case (opcode[SIZE_FIELD_MSB:SIZE_FIELD_LSB])
         SIZE_CODE_1B:   size = SIZE_1;
         SIZE_CODE_2B:   size = SIZE_2;
         SIZE_CODE_3B:   size = SIZE_3;
         SIZE_CODE_RSVD: size = SIZE_1;
         default:        size = SIZE_1;
      endcase
   end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: reads 1-3 instruction bytes at the PC, presents them over valid/ready,
// and releases the PC (pc_halt low for one cycle) once per accepted instruction.
module instr_fetch_unit
   import cpu_pkg::*;
#(
   parameter int ADDR_WIDTH = 9,
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [ADDR_WIDTH-1:0] pc,
   output logic                  pc_halt,
   output logic [1:0]            instr_size,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic                  mem_rd_en,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   output logic                  instr_valid,
   input  logic                  instr_ready,
   output logic [DATA_WIDTH-1:0] opcode,
   output logic [DATA_WIDTH-1:0] operand0,
   output logic [DATA_WIDTH-1:0] operand1
);

   fetch_state_e          state_q, state_d;
   logic [DATA_WIDTH-1:0] opcode_q, opcode_d;
   logic [DATA_WIDTH-1:0] operand0_q, operand0_d;
   logic [DATA_WIDTH-1:0] operand1_q, operand1_d;
   logic [1:0]            size_q, size_d;
   logic                  pc_halt_q, pc_halt_d;
   logic                  instr_valid_q, instr_valid_d;
   logic                  rd_en;
   logic [1:0]            byte_idx;
   logic [1:0]            rdata_size;

   instr_size_decode #(.DATA_WIDTH(DATA_WIDTH)) u_size_decode (
      .opcode (mem_rdata),
      .size   (rdata_size)
   );

   always_comb begin
      // NOTE: every signal assigned below gets a default first so no path leaves it unassigned (no latch).
      state_d    = state_q;
      opcode_d   = opcode_q;
      operand0_d = operand0_q;
      operand1_d = operand1_q;
      size_d     = size_q;
      rd_en      = 1'b0;
      byte_idx   = 2'd0;
      case (state_q)
         ST_ISSUE0: begin
            rd_en   = 1'b1;
            state_d = ST_CAP0;
         end
         ST_CAP0: begin
            // Clearing operands here makes unused operand bytes read 0 while held.
            opcode_d   = mem_rdata;
            size_d     = rdata_size;
            operand0_d = '0;
            operand1_d = '0;
            if (rdata_size != SIZE_1) begin
               rd_en    = 1'b1;
               byte_idx = 2'd1;
               state_d  = ST_CAP1;
            end else begin
               state_d = ST_HOLD;
            end
         end
         ST_CAP1: begin
            operand0_d = mem_rdata;
            if (size_q == SIZE_3) begin
               rd_en    = 1'b1;
               byte_idx = 2'd2;
               state_d  = ST_CAP2;
            end else begin
               state_d = ST_HOLD;
            end
         end
         ST_CAP2: begin
            operand1_d = mem_rdata;
            state_d    = ST_HOLD;
         end
         ST_HOLD: begin
            if (instr_ready) state_d = ST_ADVANCE;
         end
         ST_ADVANCE: state_d = ST_ISSUE0;
         default:    state_d = ST_ISSUE0;
      endcase
      pc_halt_d     = (state_d != ST_ADVANCE);
      instr_valid_d = (state_d == ST_HOLD);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= ST_ISSUE0;
         opcode_q      <= '0;
         operand0_q    <= '0;
         operand1_q    <= '0;
         size_q        <= SIZE_1;
         pc_halt_q     <= 1'b1;
         instr_valid_q <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of order.
         state_q       <= state_d;
         opcode_q      <= opcode_d;
         operand0_q    <= operand0_d;
         operand1_q    <= operand1_d;
         size_q        <= size_d;
         pc_halt_q     <= pc_halt_d;
         instr_valid_q <= instr_valid_d;
      end
   end

   // Reads are suppressed while rst is held so the reset state presents an idle memory port.
   assign mem_rd_en   = rd_en & ~rst;
   assign mem_addr    = pc + ADDR_WIDTH'(byte_idx);
   assign pc_halt     = pc_halt_q;
   assign instr_valid = instr_valid_q;
   assign instr_size  = size_q;
   assign opcode      = opcode_q;
   assign operand0    = operand0_q;
   assign operand1    = operand1_q;

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
Fetch stage between the program counter and the decoder. Reads the current PC and pulls 1-3 instruction bytes from byte-wide synchronous instruction memory. Presents the assembled instruction to the decoder over a valid/ready handshake. Drives the PC's halt and instr_size inputs so the PC advances exactly once per consumed instruction.

Parameters:
ADDR_WIDTH, 9, instruction address width; must match the PC.
DATA_WIDTH, 8, instruction memory byte width.

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-high
pc  input  ADDR_WIDTH  current PC value from the program counter
pc_halt  output  1  to PC halt; PC advances on its 1->0 transition
instr_size  output  2  to PC instr_size and to the decoder; bytes in the held instruction (1..3)
mem_addr  output  ADDR_WIDTH  instruction memory read address
mem_rd_en  output  1  memory read strobe
mem_rdata  input  DATA_WIDTH  read data, valid the cycle after mem_rd_en
instr_valid  output  1  assembled instruction available
instr_ready  input  1  decoder accepts the instruction
opcode  output  DATA_WIDTH  byte at pc
operand0  output  DATA_WIDTH  byte at pc+1 (0 if size<2)
operand1  output  DATA_WIDTH  byte at pc+2 (0 if size<3)

Behaviour:
- Size rule: decoded from opcode[7:6]: 00->1, 01->2, 10->3, 11->1 (reserved, treated as 1-byte).
- Address arithmetic: mem_addr = pc + byte_index, truncated to ADDR_WIDTH (0x1FF+1 wraps to 0x000).
- States: ISSUE0, CAP0, CAP1, CAP2, HOLD, ADVANCE.
  - ISSUE0: mem_addr=pc, mem_rd_en=1 -> CAP0.
  - CAP0: latch opcode and size. If size>=2, issue pc+1 -> CAP1. Else -> HOLD.
  - CAP1: latch operand0. If size==3, issue pc+2 -> CAP2. Else -> HOLD.
  - CAP2: latch operand1 -> HOLD.
  - HOLD: instr_valid=1. On instr_ready -> ADVANCE.
  - ADVANCE: pc_halt=0 for exactly one cycle -> ISSUE0.
- Latency: instr_valid rises size+1 cycles after entering ISSUE0.
- pc_halt=1 in every state except ADVANCE. The PC updates on the clk edge that ends ADVANCE, so ISSUE0 always sees the new pc. One instruction per handshake; no PC advance without a handshake.
- While instr_valid=1, opcode, operand0, operand1 and instr_size are stable until accepted. Unused operands read 0.
- mem_rd_en=0 in HOLD and ADVANCE. mem_addr is don't-care when mem_rd_en=0 and is driven to pc.
- instr_ready while not HOLD: ignored.
- Jumps: the execute stage drives the PC's jump_en. This block is unaware of jumps; jump_en must be valid during ADVANCE.
- Reset values: state=ISSUE0, pc_halt=1, instr_valid=0, instr_size=1, opcode=operand0=operand1=0, mem_rd_en=0.
- Reset mid-operation: all partial bytes are discarded. Fetch restarts from the PC's reset value (0) on the first cycle after rst deasserts.

Decomposition:
- Shared cpu_pkg: state encoding, SIZE_FIELD_MSB/LSB=7/6, size-code constants.
- Sub-module instr_size_decode: combinational opcode -> 2-bit size, reused by the decoder.

Test Plan:
- Mem[0]=0x05 (1-byte), ready tied 1 -> valid at cycle 2 with opcode 0x05, operands 0, size 1; pc_halt low one cycle; PC becomes 1; next fetch reads addr 1.
- Mem[1..2]=0x4A,0x33 at pc=1 -> opcode 0x4A, operand0 0x33, operand1 0, size 2, valid after 3 cycles; PC becomes 3.
- Mem[3..5]=0x81,0x12,0x34 -> 3-byte instruction assembled, valid after 4 cycles; PC becomes 6.
- instr_ready held 0 for 5 cycles in HOLD -> outputs stable, pc_halt stays 1, PC unchanged; ready=1 -> single advance.
- pc=0x1FE with 3-byte opcode 0x80 -> reads 0x1FE, 0x1FF, 0x000; PC wraps to 0x001.
- rst asserted in CAP1 -> instr_valid=0 and pc_halt=1 immediately; after release fetch restarts at addr 0.
